// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU issue scheduler.
// Optional build macro used by the top: ALU_SCHED_PERF_EN.
package alu_sched_pkg;

    // Register index width carried in the shadow stages; the top-level
    // REG_ADDR_W parameter is expected to match this value.
    localparam int SCHED_RA_W = 5;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_HOLD = 2'b10
    } sched_state_e;

    // One pipeline shadow entry; rd is zero whenever wr is clear.
    typedef struct packed {
        logic                  valid;
        logic [SCHED_RA_W-1:0] rd;
        logic                  wr;
        logic                  ld;
    } stage_t;

    // True when a live writer stage produces the register being read.
    function automatic logic stage_hit(input stage_t s, input logic [SCHED_RA_W-1:0] rs);
        return s.valid && s.wr && (rs != '0) && (s.rd == rs);
    endfunction

endpackage

// File: rtl/alu_src_decode.sv
// Opcode classifier: which sources an instruction reads, whether it writes
// rd, and whether it is a load. Unknown opcodes read and write nothing.
module alu_src_decode
    import alu_sched_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o,
    output logic       writes_rd_o,
    output logic       is_load_o
);

    // Purely combinational lookup on the major opcode
    always_comb begin
        uses_rs1_o  = 1'b0;
        uses_rs2_o  = 1'b0;
        writes_rd_o = 1'b0;
        is_load_o   = 1'b0;
        case (opcode_i)
            OPC_OP:     begin uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; writes_rd_o = 1'b1; end
            OPC_STORE,
            OPC_BRANCH: begin uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; end
            OPC_OP_IMM,
            OPC_JALR:   begin uses_rs1_o = 1'b1; writes_rd_o = 1'b1; end
            OPC_LOAD:   begin uses_rs1_o = 1'b1; writes_rd_o = 1'b1; is_load_o = 1'b1; end
            OPC_LUI,
            OPC_AUIPC,
            OPC_JAL:    writes_rd_o = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Issue scheduler for the RV32I ALU operand stage. Keeps an EX/MEM/WB
// shadow, produces registered forwarding selects, inserts a one-cycle
// load-use bubble, freezes on data-memory busy and kills EX on flush.
// Optional build macro: ALU_SCHED_PERF_EN adds saturating event counters.
module alu_issue_sched
    import alu_sched_pkg::*;
#(
    parameter int REG_ADDR_W = SCHED_RA_W
`ifdef ALU_SCHED_PERF_EN
    ,parameter int CNT_W = 32
`endif
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ID_VALID,
    output logic                  ID_READY,
    input  logic [6:0]            ID_OPCODE,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic [REG_ADDR_W-1:0] ID_RD,
    input  logic                  FLUSH,
    input  logic                  MEM_STALL,
    output logic                  EX_VALID,
    output logic [REG_ADDR_W-1:0] EX_RD,
    output logic [1:0]            FWD0_SEL,
    output logic [1:0]            FWD1_SEL
`ifdef ALU_SCHED_PERF_EN
    ,output logic [CNT_W-1:0]     ISSUE_CNT
    ,output logic [CNT_W-1:0]     LU_STALL_CNT
    ,output logic [CNT_W-1:0]     MEM_STALL_CNT
`endif
);

    logic dec_uses_rs1, dec_uses_rs2, dec_wr, dec_ld;

    alu_src_decode u_decode (
        .opcode_i    (ID_OPCODE),
        .uses_rs1_o  (dec_uses_rs1),
        .uses_rs2_o  (dec_uses_rs2),
        .writes_rd_o (dec_wr),
        .is_load_o   (dec_ld)
    );

    // Index 0 = EX, 1 = MEM, 2 = WB
    stage_t       shadow_q [3];
    fwd_sel_e     sel_q    [2];
    fwd_sel_e     sel_d    [2];
    sched_state_e state_q;

    logic [SCHED_RA_W-1:0] src_rs   [2];
    logic                  src_used [2];
    logic [1:0]            hit      [2];   // bit0: EX writer, bit1: MEM writer
    stage_t                id_stage;
    logic                  load_use;
    logic                  issue;

    assign src_rs[0]   = ID_RS1;
    assign src_rs[1]   = ID_RS2;
    assign src_used[0] = dec_uses_rs1;
    assign src_used[1] = dec_uses_rs2;

    // Per-operand producer match and forward source; the WB writer is
    // already visible through the write-first register file.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign hit[gi]   = {stage_hit(shadow_q[1], src_rs[gi]),
                                stage_hit(shadow_q[0], src_rs[gi])} & {2{src_used[gi]}};
            assign sel_d[gi] = hit[gi][0] ? FWD_EXMEM :
                               hit[gi][1] ? FWD_MEMWB : FWD_RF;
        end
    endgenerate

    // A load in EX cannot feed the next instruction in time. In LU_STALL
    // the bubble already occupies EX; the guard just bounds the stall.
    assign load_use = shadow_q[0].ld && (hit[0][0] || hit[1][0]) && (state_q != LU_STALL);
    assign ID_READY = !RESET && !FLUSH && !MEM_STALL && !load_use;
    assign issue    = ID_VALID && ID_READY;

    // Shadow entry for the instruction leaving ID; x0 is never a writer
    always_comb begin
        id_stage       = '0;
        id_stage.valid = 1'b1;
        id_stage.wr    = dec_wr && (ID_RD != '0);
        id_stage.rd    = id_stage.wr ? ID_RD : '0;
        id_stage.ld    = dec_ld;
    end

    // Shadow pipeline and registered forward selects
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
            for (int i = 0; i < 2; i++) sel_q[i] <= FWD_RF;
        end else if (FLUSH) begin
            // Killed EX entry travels on as a bubble; MEM/WB obey the freeze
            shadow_q[0] <= '0;
            for (int i = 0; i < 2; i++) sel_q[i] <= FWD_RF;
            if (!MEM_STALL) begin
                shadow_q[1] <= '0;
                shadow_q[2] <= shadow_q[1];
            end
        end else if (!MEM_STALL) begin
            // Load-use lands here with issue low, so a bubble enters EX
            shadow_q[0] <= issue ? id_stage : '0;
            shadow_q[1] <= shadow_q[0];
            shadow_q[2] <= shadow_q[1];
            for (int i = 0; i < 2; i++) sel_q[i] <= issue ? sel_d[i] : FWD_RF;
        end
    end

    assign EX_VALID = shadow_q[0].valid;
    assign EX_RD    = shadow_q[0].rd;
    assign FWD0_SEL = sel_q[0];
    assign FWD1_SEL = sel_q[1];

    // Scheduler state: RUN / LU_STALL / MEM_HOLD
    always_ff @(posedge CLK) begin
        if (RESET)                   state_q <= RUN;
        else if (MEM_STALL)          state_q <= MEM_HOLD;
        else if (load_use && !FLUSH) state_q <= LU_STALL;
        else                         state_q <= RUN;
    end

`ifdef ALU_SCHED_PERF_EN
    // Saturating event counters for issue, load-use bubble and memory hold
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ISSUE_CNT     <= '0;
            LU_STALL_CNT  <= '0;
            MEM_STALL_CNT <= '0;
        end else begin
            if (issue && (ISSUE_CNT != '1))
                ISSUE_CNT <= ISSUE_CNT + CNT_W'(1);
            if (!FLUSH && !MEM_STALL && load_use && (LU_STALL_CNT != '1))
                LU_STALL_CNT <= LU_STALL_CNT + CNT_W'(1);
            if (MEM_STALL && (MEM_STALL_CNT != '1))
                MEM_STALL_CNT <= MEM_STALL_CNT + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched with a per-cycle reference model.
module tb_alu_issue_sched;

    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] LUI    = 7'h37;

    logic       CLK = 1'b0;
    logic       RESET, ID_VALID, FLUSH, MEM_STALL;
    logic [6:0] ID_OPCODE;
    logic [4:0] ID_RS1, ID_RS2, ID_RD;
    logic       ID_READY, EX_VALID;
    logic [4:0] EX_RD;
    logic [1:0] FWD0_SEL, FWD1_SEL;
`ifdef ALU_SCHED_PERF_EN
    logic [31:0] ISSUE_CNT, LU_STALL_CNT, MEM_STALL_CNT;
`endif

    alu_issue_sched dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ID_VALID  (ID_VALID),
        .ID_READY  (ID_READY),
        .ID_OPCODE (ID_OPCODE),
        .ID_RS1    (ID_RS1),
        .ID_RS2    (ID_RS2),
        .ID_RD     (ID_RD),
        .FLUSH     (FLUSH),
        .MEM_STALL (MEM_STALL),
        .EX_VALID  (EX_VALID),
        .EX_RD     (EX_RD),
        .FWD0_SEL  (FWD0_SEL),
        .FWD1_SEL  (FWD1_SEL)
`ifdef ALU_SCHED_PERF_EN
        ,.ISSUE_CNT     (ISSUE_CNT)
        ,.LU_STALL_CNT  (LU_STALL_CNT)
        ,.MEM_STALL_CNT (MEM_STALL_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: destination register per pipeline position
    // (0 = bubble or non-writer), plus EX liveness/load flag and selects.
    int m_dest [3];
    bit m_ex_valid, m_ex_load, model_live;
    int m_f0, m_f1;
    int m_issues, m_lu, m_ms;
    bit last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Instruction class from the RV32I opcode table
    task automatic classify(input logic [6:0] op, output bit u1, output bit u2,
                            output bit wr, output bit ld);
        u1 = 0; u2 = 0; wr = 0; ld = 0;
        if (op == OP || op == STORE || op == 7'h63) begin u1 = 1; u2 = 1; end
        if (op == OP_IMM || op == LOAD || op == 7'h67) u1 = 1;
        if (op == OP || op == OP_IMM || op == LOAD || op == LUI ||
            op == 7'h17 || op == 7'h6f || op == 7'h67) wr = 1;
        ld = (op == LOAD);
    endtask

    // How far ahead the youngest producer of rs sits: 0 = EX, 1 = MEM,
    // -1 = nothing in flight (or x0).
    function automatic int age_of(input int rs);
        if (rs == 0) return -1;
        for (int i = 0; i < 2; i++)
            if (m_dest[i] == rs) return i;
        return -1;
    endfunction

    // One clock of stimulus: drive, compare at negedge, advance model
    task automatic step(input bit rst, input bit v, input bit fl, input bit st,
                        input logic [6:0] op, input int rs1, input int rs2,
                        input int rd, input string tag);
        bit u1, u2, wr, ld, lu, exp_ready, issue;
        int nf0, nf1;
        RESET = rst; ID_VALID = v; FLUSH = fl; MEM_STALL = st;
        ID_OPCODE = op; ID_RS1 = 5'(rs1); ID_RS2 = 5'(rs2); ID_RD = 5'(rd);
        classify(op, u1, u2, wr, ld);
        lu = m_ex_valid && m_ex_load && ((u1 && age_of(rs1) == 0) || (u2 && age_of(rs2) == 0));
        exp_ready = !rst && !fl && !st && !lu;
        issue = v && exp_ready;
        @(negedge CLK);
        last_ready = ID_READY;
        if (model_live) begin
            chk({tag, ".ready"}, 32'(ID_READY), 32'(exp_ready));
            chk({tag, ".ex_valid"}, 32'(EX_VALID), 32'(m_ex_valid));
            chk({tag, ".ex_rd"}, 32'(EX_RD), m_dest[0]);
            chk({tag, ".fwd0"}, 32'(FWD0_SEL), m_f0);
            chk({tag, ".fwd1"}, 32'(FWD1_SEL), m_f1);
        end
        if (rst) begin
            m_dest = '{0, 0, 0};
            m_ex_valid = 0; m_ex_load = 0; m_f0 = 0; m_f1 = 0;
            m_issues = 0; m_lu = 0; m_ms = 0;
            model_live = 1;
        end else if (fl) begin
            if (st) m_ms++;
            else begin m_dest[2] = m_dest[1]; m_dest[1] = 0; end
            m_dest[0] = 0; m_ex_valid = 0; m_ex_load = 0; m_f0 = 0; m_f1 = 0;
        end else if (st) begin
            m_ms++;
        end else begin
            if (lu) m_lu++;
            if (issue) m_issues++;
            nf0 = (issue && u1) ? age_of(rs1) + 1 : 0;
            nf1 = (issue && u2) ? age_of(rs2) + 1 : 0;
            m_dest[2] = m_dest[1];
            m_dest[1] = m_dest[0];
            m_dest[0] = (issue && wr) ? rd : 0;
            m_ex_valid = issue;
            m_ex_load = issue && ld;
            m_f0 = nf0; m_f1 = nf1;
        end
        @(posedge CLK);
        #1;
        $display("[TB] %-12s rdy=%0b ex_v=%0b ex_rd=%0d fwd0=%0d fwd1=%0d",
                 tag, last_ready, EX_VALID, EX_RD, FWD0_SEL, FWD1_SEL);
    endtask

    initial begin
        model_live = 0;
        m_dest = '{0, 0, 0};
        m_ex_valid = 0; m_ex_load = 0; m_f0 = 0; m_f1 = 0;
        m_issues = 0; m_lu = 0; m_ms = 0;
        RESET = 1; ID_VALID = 0; FLUSH = 0; MEM_STALL = 0;
        ID_OPCODE = '0; ID_RS1 = '0; ID_RS2 = '0; ID_RD = '0;

        // Reset state
        step(1, 0, 0, 0, OP, 0, 0, 0, "reset0");
        step(1, 1, 0, 0, OP, 1, 2, 3, "reset1");
        chk("rst.ready", 32'(last_ready), 0);
        chk("rst.ex_valid", 32'(EX_VALID), 0);
        chk("rst.ex_rd", 32'(EX_RD), 0);
        chk("rst.fwd0", 32'(FWD0_SEL), 0);
        chk("rst.fwd1", 32'(FWD1_SEL), 0);

        // 1: back-to-back dependent ADDs forward from EX/MEM
        step(0, 1, 0, 0, OP, 1, 2, 5, "add_x5");
        chk("t1.ex_rd", 32'(EX_RD), 5);
        step(0, 1, 0, 0, OP, 5, 3, 6, "add_x6");
        chk("t1.ready", 32'(last_ready), 1);
        chk("t1.fwd0", 32'(FWD0_SEL), 1);
        chk("t1.fwd1", 32'(FWD1_SEL), 0);

        // 2: load-use inserts one bubble, then forwards from MEM/WB
        step(0, 1, 0, 0, LOAD, 1, 0, 5, "lw_x5");
        step(0, 1, 0, 0, OP, 3, 5, 6, "lu_stall");
        chk("t2.ready_stall", 32'(last_ready), 0);
        chk("t2.bubble", 32'(EX_VALID), 0);
        step(0, 1, 0, 0, OP, 3, 5, 6, "add_after_lu");
        chk("t2.ready_go", 32'(last_ready), 1);
        chk("t2.ex_rd", 32'(EX_RD), 6);
        chk("t2.fwd1", 32'(FWD1_SEL), 2);
        chk("t2.fwd0", 32'(FWD0_SEL), 0);

        // 3: x0 never forwarded
        step(0, 1, 0, 0, OP_IMM, 0, 0, 0, "addi_x0");
        chk("t3.ex_rd0", 32'(EX_RD), 0);
        step(0, 1, 0, 0, OP, 0, 0, 7, "add_x7_x0");
        chk("t3.fwd0", 32'(FWD0_SEL), 0);
        chk("t3.fwd1", 32'(FWD1_SEL), 0);

        // 4: memory stall freezes EX for three cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, OP, 7, 7, 8, "mem_stall");
            chk("t4.ready", 32'(last_ready), 0);
            chk("t4.ex_rd", 32'(EX_RD), 7);
            chk("t4.ex_valid", 32'(EX_VALID), 1);
        end
        step(0, 1, 0, 0, OP, 7, 7, 8, "resume");
        chk("t4.fwd0", 32'(FWD0_SEL), 1);
        chk("t4.fwd1", 32'(FWD1_SEL), 1);
        chk("t4.ex_rd8", 32'(EX_RD), 8);

        // 5: flush kills EX; the killed x9 is never forwarded
        step(0, 1, 0, 0, OP, 1, 2, 9, "add_x9");
        step(0, 1, 1, 0, OP, 9, 9, 10, "flush");
        chk("t5.ready", 32'(last_ready), 0);
        chk("t5.ex_valid", 32'(EX_VALID), 0);
        step(0, 1, 0, 0, OP, 9, 9, 11, "add_x11");
        chk("t5.fwd0", 32'(FWD0_SEL), 0);
        chk("t5.fwd1", 32'(FWD1_SEL), 0);
        chk("t5.ex_rd", 32'(EX_RD), 11);

        // Flush during a memory stall, idle, then mixed producers
        step(0, 1, 1, 1, OP, 11, 11, 12, "flush_stall");
        chk("t5b.ex_valid", 32'(EX_VALID), 0);
        step(0, 0, 0, 0, OP, 0, 0, 0, "idle");
        step(0, 1, 0, 0, LUI, 0, 0, 14, "lui_x14");
        step(0, 1, 0, 0, OP, 14, 14, 15, "add_x15");
        step(0, 1, 0, 0, STORE, 15, 14, 0, "sw");
        chk("t7.fwd0", 32'(FWD0_SEL), 1);
        chk("t7.fwd1", 32'(FWD1_SEL), 2);
        chk("t7.ex_rd", 32'(EX_RD), 0);

        // 6: reset during a load-use stall clears everything
        step(0, 1, 0, 0, LOAD, 1, 0, 12, "lw_x12");
        step(1, 1, 0, 0, OP, 12, 0, 13, "rst_in_lu");
        chk("t6.ready", 32'(last_ready), 0);
        chk("t6.ex_valid", 32'(EX_VALID), 0);
        chk("t6.fwd0", 32'(FWD0_SEL), 0);
`ifdef ALU_SCHED_PERF_EN
        chk("t6.issue_cnt", ISSUE_CNT, 0);
        chk("t6.lu_cnt", LU_STALL_CNT, 0);
        chk("t6.ms_cnt", MEM_STALL_CNT, 0);
`endif
        step(0, 1, 0, 0, OP, 12, 0, 13, "add_x13");
        chk("t6.ready_go", 32'(last_ready), 1);
        chk("t6.fwd0_go", 32'(FWD0_SEL), 0);
        chk("t6.ex_rd", 32'(EX_RD), 13);

        // Extra traffic for the counters, then a final compare cycle
        step(0, 1, 0, 0, LOAD, 13, 0, 16, "lw_x16");
        step(0, 1, 0, 0, OP, 16, 16, 17, "lu_stall2");
        step(0, 1, 0, 1, OP, 16, 16, 17, "mem_stall2");
        step(0, 1, 0, 0, OP, 16, 16, 17, "add_x17");
        step(0, 0, 0, 0, OP, 0, 0, 0, "drain");
`ifdef ALU_SCHED_PERF_EN
        chk("perf.issue", ISSUE_CNT, m_issues);
        chk("perf.lu", LU_STALL_CNT, m_lu);
        chk("perf.ms", MEM_STALL_CNT, m_ms);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
